// File: rtl/pkt_frame_sched.sv
// rtl/pkt_frame_sched.sv - two-requester round-robin framer feeding the 8b/10b + CRC encoder
// Frames are 4x K28.1, payload, K28.5, then a quiet gap for the encoder's K23.7 + CRC insertion.
module pkt_frame_sched #(
  parameter int MAX_LEN    = 255,
  parameter int GAP_CYCLES = 10,
  parameter int SYNC_CNT   = 4,
  localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [7:0]       din0,
  input  logic [7:0]       din1,
  input  logic             vld0,
  input  logic             vld1,
  output logic             rdy0,
  output logic             rdy1,
  output logic             pushin,
  output logic [8:0]       datain,
  output logic             startin,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             done
);

  localparam logic [8:0] K28_1   = 9'h13C;
  localparam logic [8:0] K28_5   = 9'h1BC;
  localparam int         CNT_MAX = (GAP_CYCLES > SYNC_CNT) ? GAP_CYCLES : SYNC_CNT;
  localparam int         CNT_W   = $clog2(CNT_MAX + 1);

  if (GAP_CYCLES < 10) begin : g_bad_gap
    $error("pkt_frame_sched: GAP_CYCLES must be >= 10");
  end
  if (SYNC_CNT < 2) begin : g_bad_sync
    $error("pkt_frame_sched: SYNC_CNT must be >= 2");
  end

  typedef enum logic [2:0] {IDLE, SYNC, PAYLOAD, EOP, GAP} state_t;

  // state leads the registered outputs by one cycle: it names what is emitted at the next edge
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [LEN_W-1:0] remaining, remaining_n;
  logic             last_grant, last_grant_n;
  logic             pushin_n, startin_n, busy_n, done_n;
  logic [8:0]       datain_n;
  logic [1:0]       grant_n;
  logic             sel_vld, accept, any_req, pick, launch;
  logic [7:0]       sel_din;

  assign rdy0    = (state == PAYLOAD) && grant[0] && (remaining != '0);
  assign rdy1    = (state == PAYLOAD) && grant[1] && (remaining != '0);
  assign sel_vld = grant[1] ? vld1 : vld0;
  assign sel_din = grant[1] ? din1 : din0;
  assign accept  = sel_vld && (rdy0 || rdy1);
  assign any_req = req0 || req1;
  // on a tie the channel that did not win last time gets the grant
  assign pick    = (req0 && req1) ? ~last_grant : req1;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    remaining_n  = remaining;
    last_grant_n = last_grant;
    grant_n      = grant;
    busy_n       = busy;
    pushin_n     = 1'b0;
    datain_n     = 9'h000;
    startin_n    = 1'b0;
    done_n       = 1'b0;
    launch       = 1'b0;

    case (state)
      IDLE: launch = any_req;
      SYNC: begin
        pushin_n = 1'b1;
        datain_n = K28_1;
        cnt_n    = cnt + 1'b1;
        if (cnt == CNT_W'(SYNC_CNT - 1))
          state_n = (remaining != '0) ? PAYLOAD : EOP;
      end
      PAYLOAD: begin
        if (accept) begin
          pushin_n    = 1'b1;
          datain_n    = {1'b0, sel_din};
          remaining_n = remaining - 1'b1;
          if (remaining == LEN_W'(1))
            state_n = EOP;
        end
      end
      EOP: begin
        pushin_n = 1'b1;
        datain_n = K28_5;
        done_n   = 1'b1;
        cnt_n    = '0;
        state_n  = GAP;
      end
      GAP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CNT_W'(GAP_CYCLES)) begin
          if (any_req) begin
            launch = 1'b1;
          end else begin
            state_n = IDLE;
            grant_n = 2'b00;
            busy_n  = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // the first K28.1 goes out on the grant edge itself
    if (launch) begin
      state_n      = SYNC;
      cnt_n        = CNT_W'(1);
      last_grant_n = pick;
      grant_n      = pick ? 2'b10 : 2'b01;
      remaining_n  = pick ? len1 : len0;
      busy_n       = 1'b1;
      pushin_n     = 1'b1;
      datain_n     = K28_1;
      startin_n    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      remaining  <= '0;
      last_grant <= 1'b1;
      pushin     <= 1'b0;
      datain     <= 9'h000;
      startin    <= 1'b0;
      grant      <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      remaining  <= remaining_n;
      last_grant <= last_grant_n;
      pushin     <= pushin_n;
      datain     <= datain_n;
      startin    <= startin_n;
      grant      <= grant_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule

// File: doc/pkt_frame_sched.md
Name: pkt_frame_sched

Overview:
- Packet scheduler/framer in front of the 8b/10b encoder + CRC-insertion block (clk, reset, pushin, datain[8:0], startin).
- Arbitrates round-robin between two payload requesters and drives the encoder input with each complete frame: 4x K28.1 sync, payload bytes, then K28.5.
- Enforces the mandatory quiet gap after every K28.5 so the encoder has time to insert K23.7 and the 4-byte CRC.

Parameters:
- MAX_LEN, 255, max payload bytes per packet; LEN_W = clog2(MAX_LEN+1).
- GAP_CYCLES, 10, idle cycles after K28.5; must be >= 10 (elaboration error otherwise).
- SYNC_CNT, 4, number of K28.1 codes per frame.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req0 / req1  in  1  requester n has a packet pending; hold high until granted.
- len0 / len1  in  LEN_W  payload length of requester n; sampled at grant edge; 0 is legal.
- din0 / din1  in  8  payload byte from requester n.
- vld0 / vld1  in  1  din of requester n is valid.
- rdy0 / rdy1  out  1  scheduler accepts a byte from requester n this cycle.
- pushin  out  1  encoder input strobe.
- datain  out  9  encoder input: bit8 = K flag, bits7:0 = byte.
- startin  out  1  first code of frame; high only on the first K28.1.
- grant  out  2  one-hot current owner; 00 when idle.
- busy  out  1  frame or gap in progress.
- done  out  1  one-cycle pulse, coincident with the K28.5 cycle.

Behaviour:
- Codes:
  - K28.1 = 9'h13C.
  - K28.5 = 9'h1BC.
  - Payload = {1'b0, byte}.
  - datain = 9'h000 whenever pushin = 0.
- Reset (reset = 0 at an edge): all outputs 0, state IDLE, last_grant = 1 (so ch0 wins first).
  - Mid-frame reset truncates the frame with no K28.5.
  - The encoder shares the reset, so no recovery frame is sent.
- pushin, datain, startin, grant, busy and done are registered. rdyN is combinational: (state == PAYLOAD) && grant[N] && (remaining > 0).
- States: IDLE, SYNC, PAYLOAD, EOP, GAP.
- IDLE:
  - At an edge with any req high, grant the requester; if both are high, grant the one != last_grant.
  - Latch lenN into remaining, update last_grant, go to SYNC.
  - A req dropped before the edge is ignored.
- SYNC (SYNC_CNT cycles):
  - pushin = 1, datain = K28.1; startin = 1 only in the first cycle.
  - In the last SYNC cycle, rdy is already high if remaining > 0, so payload follows back-to-back.
  - If remaining = 0, go from SYNC directly to EOP.
- PAYLOAD:
  - A byte accepted (vld & rdy) at edge n appears on datain with pushin = 1 in cycle n+1; remaining decrements.
  - If vld is low (stall), pushin = 0 the next cycle. Stalls are unbounded, and the requester is never preempted.
  - When the last byte is accepted, the next cycle outputs that byte and the state goes to EOP.
- EOP (1 cycle): pushin = 1, datain = K28.5, done = 1.
- GAP: pushin = 0 for exactly GAP_CYCLES cycles; grant is held, busy = 1.
  - Requests are not arbitrated until the last GAP cycle's edge.
  - Then grant = 00, busy = 0 (IDLE), or an immediate new grant if req is pending (no IDLE cycle).
- Reference timing (req0 sampled at end of cycle 0, len = L, no stalls):
  - Cycles 1..4: K28.1; startin in cycle 1 only; grant = 01, busy = 1 from cycle 1.
  - Cycles 5..4+L: payload.
  - Cycle 5+L: K28.5 + done.
  - Cycles 6+L..5+L+GAP: idle.
  - Next frame's first K28.1 no earlier than cycle 6+L+GAP.
- rdy of the non-granted requester is always 0. vld without rdy has no effect.
- len > MAX_LEN is impossible by width.

Test Plan:
- Reset then req0 = 1, len0 = 3, bytes A1 A2 A3 always valid -> cycles 1–8 datain = 13C 13C 13C 13C 0A1 0A2 0A3 1BC; startin only cycle 1; done cycle 8; pushin = 0 cycles 9–18.
- req0 and req1 high together, len = 1 each -> ch0 frame first; ch1 first K28.1 exactly 11 cycles after ch0's K28.5; grant 01 then 10; third simultaneous request goes to ch0.
- len0 = 0 -> 4x 13C then 1BC in cycle 5; rdy0 never asserted.
- len1 = 4, vld1 low for 3 cycles after byte 2 -> pushin = 0 for 3 cycles mid-payload, datain = 000; bytes stay in order; single 1BC at end.
- reset low during payload byte 2 of a 10-byte frame -> next cycle all outputs 0, no 1BC; req0 afterwards gets a full fresh frame with startin.
- Continuous requests for 100 frames (random len 0..255, random stalls) -> every 1BC followed by >= 10 pushin-low cycles; grants alternate; frame byte counts match len.
